riscv_retire_trace_checker: RTL and testbench
=============================================

// Module: riscv_retire_trace_checker
// PURPOSE
//  Bench-side self-checking monitor for the multicycle RV32 core. Holds a programmable table of
//  expected retirements (PC, optional rd/value) and compares each retirement reported by the core.
//  Covers both branch/jump targets and register writeback. Produces pass/fail, mismatch count,
//  first-failure index/code, and a watchdog timeout for hung cores.
//  Synthesisable RTL; sits beside riscv_core in every directed testbench.
// PARAMETERS
//  XLEN           32  data/PC width
//  DEPTH          16  expected-trace table entries (>=2)
//  TIMEOUT_CYCLES 64  max cycles between retirements (or start->first retire) before timeout
//  STOP_ON_FAIL   0   1: finish on first mismatch; 0: run full trace, count all mismatches
// PORTS
//  clk              in   1                  clock, rising edge
//  reset            in   1                  asynchronous, active-low reset
//  tr_wr_en         in   1                  write one table entry this cycle
//  tr_wr_idx        in   $clog2(DEPTH)      entry index
//  tr_wr_pc         in   XLEN               expected retire PC
//  tr_wr_chk_rd     in   1                  1: also check rd write
//  tr_wr_rd         in   5                  expected rd
//  tr_wr_data       in   XLEN               expected rd value
//  start            in   1                  pulse: begin checking
//  trace_len        in   $clog2(DEPTH+1)    entries to check, sampled on start
//  retire_valid     in   1                  core retired one instruction this cycle
//  retire_pc        in   XLEN               PC of retired instruction
//  retire_rd_wr_en  in   1                  retired instruction wrote a register
//  retire_rd        in   5                  destination register
//  retire_rd_data   in   XLEN               value written
//  busy             out  1                  state==RUN
//  done             out  1                  state==DONE
//  pass             out  1                  done & no mismatch & no timeout
//  timeout          out  1                  watchdog expired
//  err_count        out  8                  mismatches, saturates at 255
//  first_fail_idx   out  $clog2(DEPTH)      index of first mismatch
//  fail_code        out  2                  0 none, 1 PC, 2 rd/data, 3 timeout (first failure)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; all outputs 0; idx, wdog, err_count cleared. Table not
//    cleared (contents X until written). Reset mid-RUN aborts; no done pulse.
//  - Table write: tr_wr_en in IDLE or DONE writes entry at next edge. Writes while busy ignored.
//  - FSM IDLE/RUN/DONE. IDLE --start--> RUN (idx=0, wdog=0, err_count=0, fail_code=0, timeout=0).
//    start with trace_len==0 -> DONE, pass=1. trace_len>DEPTH is clamped to DEPTH.
//  - DONE --start--> RUN (restart, same rules). start while RUN ignored.
//  - RUN, retire_valid: compare against entry[idx]:
//    PC mismatch  = retire_pc!=exp_pc.
//    Data mismatch = chk_rd & !(retire_rd_wr_en & retire_rd==exp_rd & retire_rd_data==exp_data).
//    Either -> err_count+1 (sat); if first failure, latch idx and code (PC wins over data).
//    idx++; wdog=0. If idx was len-1, or (STOP_ON_FAIL & mismatch) -> DONE.
//  - RUN, no retire: wdog++; wdog reaching TIMEOUT_CYCLES-1 with no retire -> DONE, timeout=1,
//    fail_code=3 if no prior failure. A retire on that cycle wins (timeout not set).
//  - retire_valid outside RUN ignored. Comparison is registered: outputs update on the edge
//    after the retirement; done rises the edge after the final retirement.
//  - pass = done & err_count==0 & !timeout. DONE holds all outputs until start or reset.
// TESTING
//  1. Load PCs 0x0,0x4,0x8,0xC,0x14 (BEQ skip), len=5; drive matching retires -> done=1 pass=1 err=0.
//  2. Entry 3 expects 0x14, drive 0x10 (STOP_ON_FAIL=0) -> pass=0 err=1 first_fail_idx=3 fail_code=1,
//     done after all 5 retires.
//  3. Entry 0 chk_rd x1=0x80000000; retire x1=0x80000004 -> fail_code=2 idx=0; with STOP_ON_FAIL=1
//     done next edge.
//  4. start, then no retire_valid for 64 cycles -> timeout=1 fail_code=3 pass=0; retire on cycle 63 -> no timeout.
//  5. Assert reset low mid-RUN at idx=2 -> all outputs 0 immediately; restart with start -> full pass.
//  6. 300 mismatching retires with DEPTH=512 variant -> err_count=255 (saturated); len=0 start -> pass=1 next edge.

Source files
------------

// File: rtl/riscv_retire_trace_checker.sv
// Retirement trace checker: compares each core retirement against a programmable
// table of expected PCs and optional rd writebacks, with a watchdog for hung cores.
module riscv_retire_trace_checker #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STOP_ON_FAIL   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tr_wr_en,
  input  logic [$clog2(DEPTH)-1:0]     tr_wr_idx,
  input  logic [XLEN-1:0]              tr_wr_pc,
  input  logic                         tr_wr_chk_rd,
  input  logic [4:0]                   tr_wr_rd,
  input  logic [XLEN-1:0]              tr_wr_data,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   trace_len,
  input  logic                         retire_valid,
  input  logic [XLEN-1:0]              retire_pc,
  input  logic                         retire_rd_wr_en,
  input  logic [4:0]                   retire_rd,
  input  logic [XLEN-1:0]              retire_rd_data,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [7:0]                   err_count,
  output logic [$clog2(DEPTH)-1:0]     first_fail_idx,
  output logic [1:0]                   fail_code
);

  localparam int IW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH+1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [7:0]        err_q, err_d;
  logic [IW-1:0]     ffi_q, ffi_d;
  logic [1:0]        code_q, code_d;
  logic              tmo_q, tmo_d;

  // Expected-trace table; deliberately not reset so reset leaves programmed traces intact.
  logic [XLEN-1:0]   tbl_pc_q   [DEPTH];
  logic              tbl_chk_q  [DEPTH];
  logic [4:0]        tbl_rd_q   [DEPTH];
  logic [XLEN-1:0]   tbl_data_q [DEPTH];

  always_ff @(posedge clk) begin
    if (tr_wr_en && (state_q != RUN)) begin
      tbl_pc_q[tr_wr_idx]   <= tr_wr_pc;
      tbl_chk_q[tr_wr_idx]  <= tr_wr_chk_rd;
      tbl_rd_q[tr_wr_idx]   <= tr_wr_rd;
      tbl_data_q[tr_wr_idx] <= tr_wr_data;
    end
  end

  logic          pc_mis, data_mis, mis, last;
  logic [LW-1:0] len_eff;

  always_comb begin
    pc_mis   = (retire_pc != tbl_pc_q[idx_q]);
    data_mis = tbl_chk_q[idx_q] &
               !(retire_rd_wr_en && (retire_rd == tbl_rd_q[idx_q]) &&
                 (retire_rd_data == tbl_data_q[idx_q]));
    mis      = pc_mis | data_mis;
    last     = ((LW'(idx_q) + LW'(1)) == len_q);
    len_eff  = (trace_len > LW'(DEPTH)) ? LW'(DEPTH) : trace_len;

    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    code_d  = code_q;
    tmo_d   = tmo_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          wdog_d  = '0;
          err_d   = '0;
          ffi_d   = '0;
          code_d  = '0;
          tmo_d   = 1'b0;
          len_d   = len_eff;
          state_d = (len_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (retire_valid) begin
          if (mis) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (code_q == 2'd0) begin
              code_d = pc_mis ? 2'd1 : 2'd2;
              ffi_d  = idx_q;
            end
          end
          idx_d  = idx_q + IW'(1);
          wdog_d = '0;
          if (last || ((STOP_ON_FAIL != 0) && mis)) state_d = DONE;
        end else if (wdog_q == WDW'(TIMEOUT_CYCLES-1)) begin
          // A retirement in the final watchdog cycle takes priority over the timeout.
          state_d = DONE;
          tmo_d   = 1'b1;
          if (code_q == 2'd0) code_d = 2'd3;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      wdog_q  <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      code_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_q == 8'd0) && !tmo_q;
  assign timeout        = tmo_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign fail_code      = code_q;

endmodule

// File: tb/tb_riscv_retire_trace_checker.sv
// Directed bench for riscv_retire_trace_checker: three instances (continue-on-fail,
// stop-on-fail, deep table) share one stimulus bus; each check targets one instance.
module tb_riscv_retire_trace_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tr_wr_en, wr_chk, start, rv, rwr;
  logic [8:0]  wr_idx;
  logic [31:0] wr_pc, wr_data, rpc, rdata;
  logic [4:0]  wr_rd, rrd;
  logic [9:0]  tlen;

  logic       b0, dn0, p0, to0, b1, dn1, p1, to1, b2, dn2, p2, to2;
  logic [7:0] e0, e1, e2;
  logic [3:0] f0, f1;
  logic [8:0] f2;
  logic [1:0] c0, c1, c2;

  riscv_retire_trace_checker #(.XLEN(32), .DEPTH(16), .TIMEOUT_CYCLES(64), .STOP_ON_FAIL(0)) u_d0 (
    .clk(clk), .reset(reset), .tr_wr_en(tr_wr_en), .tr_wr_idx(wr_idx[3:0]), .tr_wr_pc(wr_pc),
    .tr_wr_chk_rd(wr_chk), .tr_wr_rd(wr_rd), .tr_wr_data(wr_data), .start(start),
    .trace_len(tlen[4:0]), .retire_valid(rv), .retire_pc(rpc), .retire_rd_wr_en(rwr),
    .retire_rd(rrd), .retire_rd_data(rdata), .busy(b0), .done(dn0), .pass(p0), .timeout(to0),
    .err_count(e0), .first_fail_idx(f0), .fail_code(c0));

  riscv_retire_trace_checker #(.XLEN(32), .DEPTH(16), .TIMEOUT_CYCLES(64), .STOP_ON_FAIL(1)) u_d1 (
    .clk(clk), .reset(reset), .tr_wr_en(tr_wr_en), .tr_wr_idx(wr_idx[3:0]), .tr_wr_pc(wr_pc),
    .tr_wr_chk_rd(wr_chk), .tr_wr_rd(wr_rd), .tr_wr_data(wr_data), .start(start),
    .trace_len(tlen[4:0]), .retire_valid(rv), .retire_pc(rpc), .retire_rd_wr_en(rwr),
    .retire_rd(rrd), .retire_rd_data(rdata), .busy(b1), .done(dn1), .pass(p1), .timeout(to1),
    .err_count(e1), .first_fail_idx(f1), .fail_code(c1));

  riscv_retire_trace_checker #(.XLEN(32), .DEPTH(512), .TIMEOUT_CYCLES(64), .STOP_ON_FAIL(0)) u_d2 (
    .clk(clk), .reset(reset), .tr_wr_en(tr_wr_en), .tr_wr_idx(wr_idx), .tr_wr_pc(wr_pc),
    .tr_wr_chk_rd(wr_chk), .tr_wr_rd(wr_rd), .tr_wr_data(wr_data), .start(start),
    .trace_len(tlen), .retire_valid(rv), .retire_pc(rpc), .retire_rd_wr_en(rwr),
    .retire_rd(rrd), .retire_rd_data(rdata), .busy(b2), .done(dn2), .pass(p2), .timeout(to2),
    .err_count(e2), .first_fail_idx(f2), .fail_code(c2));

  typedef struct {
    logic [31:0] exp_pc;
    logic        chk;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [31:0] ret_pc;
    logic        ret_wr;
    logic [4:0]  ret_rd;
    logic [31:0] ret_data;
    logic [7:0]  exp_err;
    logic        exp_done;
  } vec_t;

  vec_t vt[15];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int idx, input logic [31:0] pc, input logic c,
                          input logic [4:0] rd, input logic [31:0] data);
    tr_wr_en = 1'b1; wr_idx = 9'(idx); wr_pc = pc; wr_chk = c; wr_rd = rd; wr_data = data;
    tick();
    tr_wr_en = 1'b0;
  endtask

  task automatic do_start(input int len);
    start = 1'b1; tlen = 10'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic w, input logic [4:0] rd,
                        input logic [31:0] data);
    rv = 1'b1; rpc = pc; rwr = w; rrd = rd; rdata = data;
    tick();
    rv = 1'b0;
  endtask

  // Loads vt[first..first+n-1] into the table, runs them, checks u_d0 step by step.
  task automatic run_scn(input string nm, input int first, input int n, input logic exp_pass,
                         input int exp_ffi, input int exp_code, input int exp_d1_stop);
    int d1_first;
    d1_first = -1;
    for (int k = 0; k < n; k++)
      wr_entry(k, vt[first+k].exp_pc, vt[first+k].chk, vt[first+k].exp_rd, vt[first+k].exp_data);
    do_start(n);
    chk($sformatf("%s busy after start", nm), 32'(b0), 32'd1);
    for (int k = 0; k < n; k++) begin
      retire(vt[first+k].ret_pc, vt[first+k].ret_wr, vt[first+k].ret_rd, vt[first+k].ret_data);
      chk($sformatf("%s err step %0d", nm, k), 32'(e0), 32'(vt[first+k].exp_err));
      chk($sformatf("%s done step %0d", nm, k), 32'(dn0), 32'(vt[first+k].exp_done));
      if (dn1 && d1_first < 0) d1_first = k;
    end
    chk($sformatf("%s pass", nm), 32'(p0), 32'(exp_pass));
    chk($sformatf("%s first_fail_idx", nm), 32'(f0), 32'(exp_ffi));
    chk($sformatf("%s fail_code", nm), 32'(c0), 32'(exp_code));
    chk($sformatf("%s timeout", nm), 32'(to0), 32'd0);
    chk($sformatf("%s stop-on-fail done step", nm), 32'(d1_first), 32'(exp_d1_stop));
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // S1: BEQ-skip program, all match (some with rd checks)
    vt[0]  = '{32'h00, 1'b0, 5'd0, 32'h0,    32'h00, 1'b1, 5'd1, 32'h5,    8'd0, 1'b0};
    vt[1]  = '{32'h04, 1'b1, 5'd5, 32'h1234, 32'h04, 1'b1, 5'd5, 32'h1234, 8'd0, 1'b0};
    vt[2]  = '{32'h08, 1'b0, 5'd0, 32'h0,    32'h08, 1'b0, 5'd0, 32'h0,    8'd0, 1'b0};
    vt[3]  = '{32'h0C, 1'b1, 5'd2, 32'h0,    32'h0C, 1'b1, 5'd2, 32'h0,    8'd0, 1'b0};
    vt[4]  = '{32'h14, 1'b0, 5'd0, 32'h0,    32'h14, 1'b0, 5'd0, 32'h0,    8'd0, 1'b1};
    // S2: wrong branch target at entry 3
    vt[5]  = '{32'h00, 1'b0, 5'd0, 32'h0,    32'h00, 1'b0, 5'd0, 32'h0,    8'd0, 1'b0};
    vt[6]  = '{32'h04, 1'b0, 5'd0, 32'h0,    32'h04, 1'b0, 5'd0, 32'h0,    8'd0, 1'b0};
    vt[7]  = '{32'h08, 1'b0, 5'd0, 32'h0,    32'h08, 1'b0, 5'd0, 32'h0,    8'd0, 1'b0};
    vt[8]  = '{32'h14, 1'b0, 5'd0, 32'h0,    32'h10, 1'b0, 5'd0, 32'h0,    8'd1, 1'b0};
    vt[9]  = '{32'h18, 1'b0, 5'd0, 32'h0,    32'h18, 1'b0, 5'd0, 32'h0,    8'd1, 1'b1};
    // S3: data, missing-write and wrong-rd mismatches
    vt[10] = '{32'h00, 1'b1, 5'd1, 32'h80000000, 32'h00, 1'b1, 5'd1, 32'h80000004, 8'd1, 1'b0};
    vt[11] = '{32'h04, 1'b1, 5'd2, 32'h7,        32'h04, 1'b0, 5'd2, 32'h7,        8'd2, 1'b0};
    vt[12] = '{32'h08, 1'b1, 5'd3, 32'h9,        32'h08, 1'b1, 5'd4, 32'h9,        8'd3, 1'b1};
    // S4: PC and data both wrong -> PC code wins
    vt[13] = '{32'h100, 1'b1, 5'd1, 32'h1, 32'h104, 1'b1, 5'd1, 32'h2, 8'd1, 1'b0};
    vt[14] = '{32'h108, 1'b0, 5'd0, 32'h0, 32'h108, 1'b0, 5'd0, 32'h0, 8'd1, 1'b1};

    reset = 1'b0; tr_wr_en = 1'b0; wr_idx = '0; wr_pc = '0; wr_chk = 1'b0; wr_rd = '0;
    wr_data = '0; start = 1'b0; tlen = '0; rv = 1'b0; rpc = '0; rwr = 1'b0; rrd = '0; rdata = '0;
    tick(); tick();
    chk("reset busy", 32'(b0), 32'd0);
    chk("reset done", 32'(dn0), 32'd0);
    chk("reset pass", 32'(p0), 32'd0);
    chk("reset err", 32'(e0), 32'd0);
    chk("reset code", 32'(c0), 32'd0);
    reset = 1'b1;
    tick();

    run_scn("S1", 0, 5, 1'b1, 0, 0, 4);
    run_scn("S2", 5, 5, 1'b0, 3, 1, 3);
    chk("S2 sof code", 32'(c1), 32'd1);
    chk("S2 sof ffi", 32'(f1), 32'd3);
    run_scn("S3", 10, 3, 1'b0, 0, 2, 0);
    chk("S3 sof err", 32'(e1), 32'd1);
    chk("S3 sof code", 32'(c1), 32'd2);
    run_scn("S4", 13, 2, 1'b0, 0, 1, 0);

    // trace_len above DEPTH clamps to DEPTH
    for (int i = 0; i < 16; i++) wr_entry(i, 32'(i*4), 1'b0, 5'd0, 32'd0);
    do_start(20);
    for (int i = 0; i < 15; i++) retire(32'(i*4), 1'b0, 5'd0, 32'd0);
    chk("clamp busy at 15", 32'(b0), 32'd1);
    retire(32'd60, 1'b0, 5'd0, 32'd0);
    chk("clamp done at 16", 32'(dn0), 32'd1);
    chk("clamp pass", 32'(p0), 32'd1);

    // table write while busy is ignored; retire outside RUN ignored
    wr_entry(0, 32'h40, 1'b0, 5'd0, 32'd0);
    do_start(1);
    wr_entry(0, 32'h99, 1'b0, 5'd0, 32'd0);
    retire(32'h40, 1'b0, 5'd0, 32'd0);
    chk("busy-write pass", 32'(p0), 32'd1);
    retire(32'h77, 1'b0, 5'd0, 32'd0);
    chk("idle retire err", 32'(e0), 32'd0);
    chk("idle retire done", 32'(dn0), 32'd1);

    // watchdog: 64 silent cycles time out
    wr_entry(0, 32'h200, 1'b0, 5'd0, 32'd0);
    do_start(1);
    repeat (63) tick();
    chk("wdog done at 63", 32'(dn0), 32'd0);
    tick();
    chk("wdog timeout", 32'(to0), 32'd1);
    chk("wdog done", 32'(dn0), 32'd1);
    chk("wdog code", 32'(c0), 32'd3);
    chk("wdog pass", 32'(p0), 32'd0);
    // retire in the last watchdog cycle wins
    do_start(1);
    repeat (63) tick();
    retire(32'h200, 1'b0, 5'd0, 32'd0);
    chk("wdog edge timeout", 32'(to0), 32'd0);
    chk("wdog edge pass", 32'(p0), 32'd1);

    // reset mid-RUN at idx 2 with errors pending
    for (int k = 0; k < 3; k++)
      wr_entry(k, vt[10+k].exp_pc, vt[10+k].chk, vt[10+k].exp_rd, vt[10+k].exp_data);
    do_start(3);
    retire(vt[10].ret_pc, vt[10].ret_wr, vt[10].ret_rd, vt[10].ret_data);
    retire(vt[11].ret_pc, vt[11].ret_wr, vt[11].ret_rd, vt[11].ret_data);
    chk("pre-reset err", 32'(e0), 32'd2);
    reset = 1'b0;
    #1;
    chk("async reset busy", 32'(b0), 32'd0);
    chk("async reset err", 32'(e0), 32'd0);
    chk("async reset code", 32'(c0), 32'd0);
    chk("async reset done", 32'(dn0), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_scn("S1r", 0, 5, 1'b1, 0, 0, 4);

    // deep table: err_count saturates at 255
    for (int i = 0; i < 300; i++) wr_entry(i, 32'(i*4), 1'b0, 5'd0, 32'd0);
    do_start(300);
    for (int i = 0; i < 255; i++) retire(32'(i*4+2), 1'b0, 5'd0, 32'd0);
    chk("sat err at 255", 32'(e2), 32'd255);
    for (int i = 255; i < 300; i++) retire(32'(i*4+2), 1'b0, 5'd0, 32'd0);
    chk("sat err", 32'(e2), 32'd255);
    chk("sat done", 32'(dn2), 32'd1);
    chk("sat pass", 32'(p2), 32'd0);
    chk("sat ffi", 32'(f2), 32'd0);
    chk("sat code", 32'(c2), 32'd1);
    do_start(0);
    chk("len0 done", 32'(dn2), 32'd1);
    chk("len0 pass", 32'(p2), 32'd1);
    chk("len0 err", 32'(e2), 32'd0);
    chk("len0 busy", 32'(b2), 32'd0);
    chk("len0 pass d0", 32'(p0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
